alu_reservation_station: RTL and testbench

- Buffers decoded ALU and branch instructions until both source operands are available.
- Captures pending operands from the common data bus (CDB).
- Each cycle, dispatches at most one ready entry to the downstream combinational ALU through registered outputs.
- Sits between the decoder/issue stage and the ALU; the ROB tag rides along as the ALU's rd.

---
 rtl/alu_reservation_station.sv | 188 ++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// alu_reservation_station
// Holds decoded ALU/branch instructions until both source operands are
// available, snoops the common data bus for pending operands, and hands at
// most one ready entry per cycle to the combinational ALU through registered
// outputs. The ROB tag travels with the entry and leaves as alu_rd.
//
// Optional feature macro: RS_WAKEUP_BYPASS_EN
//   When defined, an entry whose pending operands all match the current CDB
//   broadcast may dispatch in the same cycle, taking cdb_value directly.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global stall when low),
//   clear_in (flush)
//   issue_*  : instruction from the decoder (valid, op, operands, tags, imm, pc)
//   cdb_*    : result broadcast (valid, tag, value)
//   full_out : every entry busy (combinational)
//   alu_*    : registered dispatch to the ALU (alu_op == 0 means no dispatch)
module alu_reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             issue_valid,
  input  logic [6:0]       issue_op,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             full_out,
  output logic [6:0]       alu_op,
  output logic [31:0]      alu_vi,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [TAG_W-1:0] alu_rd
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage; busy_r alone encodes FREE (0) / WAIT (1).
  logic [RS_SIZE-1:0] busy_r;
  logic [RS_SIZE-1:0] qj_busy_r;
  logic [RS_SIZE-1:0] qk_busy_r;
  logic [6:0]         op_r  [RS_SIZE];
  logic [31:0]        vj_r  [RS_SIZE];
  logic [31:0]        vk_r  [RS_SIZE];
  logic [31:0]        imm_r [RS_SIZE];
  logic [31:0]        pc_r  [RS_SIZE];
  logic [TAG_W-1:0]   qj_r  [RS_SIZE];
  logic [TAG_W-1:0]   qk_r  [RS_SIZE];
  logic [TAG_W-1:0]   tag_r [RS_SIZE];

  logic [RS_SIZE-1:0] match_j_s;
  logic [RS_SIZE-1:0] match_k_s;
  logic [RS_SIZE-1:0] ready_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [IDX_W-1:0]   disp_idx_s;
  logic               disp_valid_s;
  logic               issue_accept_s;
  logic               issue_hit_j_s;
  logic               issue_hit_k_s;
  logic [31:0]        disp_vi_s;
  logic [31:0]        disp_vk_s;

  // Full is judged on pre-edge busy bits, so a same-cycle dispatch never frees room for issue.
  assign full_out = &busy_r;

  // Opcode 0 is the "no dispatch" marker, so such issues are dropped.
  assign issue_accept_s = issue_valid && !full_out && !clear_in && (issue_op != 7'd0);

  // The instruction being issued can catch this cycle's broadcast directly.
  assign issue_hit_j_s = cdb_valid && issue_qj_busy && (issue_qj == cdb_tag);
  assign issue_hit_k_s = cdb_valid && issue_qk_busy && (issue_qk == cdb_tag);

  // Per-entry CDB tag match and readiness.
  always_comb begin
    match_j_s = {RS_SIZE{1'b0}};
    match_k_s = {RS_SIZE{1'b0}};
    ready_s   = {RS_SIZE{1'b0}};
    for (int i = 0; i < RS_SIZE; i++) begin
      match_j_s[i] = cdb_valid && qj_busy_r[i] && (qj_r[i] == cdb_tag);
      match_k_s[i] = cdb_valid && qk_busy_r[i] && (qk_r[i] == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
      ready_s[i] = busy_r[i] && (!qj_busy_r[i] || match_j_s[i])
                             && (!qk_busy_r[i] || match_k_s[i]);
`else
      ready_s[i] = busy_r[i] && !qj_busy_r[i] && !qk_busy_r[i];
`endif
    end
  end

  // Lowest-index free entry and lowest-index ready entry (scan from the top down).
  always_comb begin
    free_idx_s = {IDX_W{1'b0}};
    disp_idx_s = {IDX_W{1'b0}};
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx_s = busy_r[i]  ? free_idx_s : IDX_W'(i);
      disp_idx_s = ready_s[i] ? IDX_W'(i)  : disp_idx_s;
    end
    disp_valid_s = |ready_s;
  end

  // Operand values for the selected entry; a still-pending operand can only be a bypass hit.
  always_comb begin
    disp_vi_s = vj_r[disp_idx_s];
    disp_vk_s = vk_r[disp_idx_s];
`ifdef RS_WAKEUP_BYPASS_EN
    if (qj_busy_r[disp_idx_s]) begin
      disp_vi_s = cdb_value;
    end else begin
      disp_vi_s = vj_r[disp_idx_s];
    end
    if (qk_busy_r[disp_idx_s]) begin
      disp_vk_s = cdb_value;
    end else begin
      disp_vk_s = vk_r[disp_idx_s];
    end
`endif
  end

  // Entry state, wakeup, issue, dispatch and the registered ALU outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_r    <= {RS_SIZE{1'b0}};
      qj_busy_r <= {RS_SIZE{1'b0}};
      qk_busy_r <= {RS_SIZE{1'b0}};
      alu_op    <= 7'd0;
      alu_vi    <= 32'd0;
      alu_vj    <= 32'd0;
      alu_imm   <= 32'd0;
      alu_pc    <= 32'd0;
      alu_rd    <= {TAG_W{1'b0}};
    end else if (rdy_in) begin
      if (clear_in) begin
        busy_r <= {RS_SIZE{1'b0}};
        alu_op <= 7'd0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_r[i] && match_j_s[i]) begin
            vj_r[i]      <= cdb_value;
            qj_busy_r[i] <= 1'b0;
          end
          if (busy_r[i] && match_k_s[i]) begin
            vk_r[i]      <= cdb_value;
            qk_busy_r[i] <= 1'b0;
          end
        end
        if (disp_valid_s) begin
          alu_op             <= op_r[disp_idx_s];
          alu_vi             <= disp_vi_s;
          alu_vj             <= disp_vk_s;
          alu_imm            <= imm_r[disp_idx_s];
          alu_pc             <= pc_r[disp_idx_s];
          alu_rd             <= tag_r[disp_idx_s];
          busy_r[disp_idx_s] <= 1'b0;
        end else begin
          alu_op <= 7'd0;
        end
        // The free slot is never the dispatched one, so both writes coexist.
        if (issue_accept_s) begin
          busy_r[free_idx_s]    <= 1'b1;
          op_r[free_idx_s]      <= issue_op;
          vj_r[free_idx_s]      <= issue_hit_j_s ? cdb_value : issue_vj;
          vk_r[free_idx_s]      <= issue_hit_k_s ? cdb_value : issue_vk;
          qj_busy_r[free_idx_s] <= issue_qj_busy && !issue_hit_j_s;
          qk_busy_r[free_idx_s] <= issue_qk_busy && !issue_hit_k_s;
          qj_r[free_idx_s]      <= issue_qj;
          qk_r[free_idx_s]      <= issue_qk;
          imm_r[free_idx_s]     <= issue_imm;
          pc_r[free_idx_s]      <= issue_pc;
          tag_r[free_idx_s]     <= issue_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

  localparam int TAG_W = 5;

  logic             clk_in, rst_in, rdy_in, clear_in;
  logic             issue_valid;
  logic [6:0]       issue_op;
  logic [31:0]      issue_vj, issue_vk, issue_imm, issue_pc;
  logic             issue_qj_busy, issue_qk_busy;
  logic [TAG_W-1:0] issue_qj, issue_qk, issue_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             full_out;
  logic [6:0]       alu_op;
  logic [31:0]      alu_vi, alu_vj, alu_imm, alu_pc;
  logic [TAG_W-1:0] alu_rd;

  typedef struct packed {
    logic [6:0]       op;
    logic [31:0]      vi;
    logic [31:0]      vj;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_reservation_station #(.RS_SIZE(8), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .full_out(full_out), .alu_op(alu_op), .alu_vi(alu_vi), .alu_vj(alu_vj),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rd(alu_rd)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare any live dispatch against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (rdy_in && !rst_in && !clear_in && alu_op !== 7'd0) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed_op=%0h rd=%0h expected=no_dispatch", alu_op, alu_rd);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_op",  {25'd0, alu_op}, {25'd0, e.op});
        chk("sb_vi",  alu_vi, e.vi);
        chk("sb_vj",  alu_vj, e.vj);
        chk("sb_imm", alu_imm, e.imm);
        chk("sb_pc",  alu_pc, e.pc);
        chk("sb_rd",  {27'd0, alu_rd}, {27'd0, e.rd});
      end
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_op = 7'd0; issue_vj = 32'd0; issue_vk = 32'd0;
    issue_qj_busy = 1'b0; issue_qk_busy = 1'b0; issue_qj = 5'd0; issue_qk = 5'd0;
    issue_imm = 32'd0; issue_pc = 32'd0; issue_tag = 5'd0;
    cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0;
  endtask

  task automatic set_issue(input logic [6:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic qjb, input logic [4:0] qj, input logic qkb,
                           input logic [4:0] qk, input logic [4:0] tag);
    issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk;
    issue_imm = {27'd0, tag} + 32'h100; issue_pc = {27'd0, tag} << 2; issue_tag = tag;
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [31:0] vi,
                              input logic [31:0] vj, input logic [4:0] tag);
    exp_t e;
    e.op = op; e.vi = vi; e.vj = vj; e.rd = tag;
    e.imm = {27'd0, tag} + 32'h100; e.pc = {27'd0, tag} << 2;
    return e;
  endfunction

  initial begin
    idle();
    rdy_in = 1'b1; clear_in = 1'b0; rst_in = 1'b1;

    // Reset then idle
    tick(); tick();
    chk("rst_op",   {25'd0, alu_op}, 32'd0);
    chk("rst_full", {31'd0, full_out}, 32'd0);
    chk("rst_vi",   alu_vi, 32'd0);
    chk("rst_vj",   alu_vj, 32'd0);
    chk("rst_imm",  alu_imm, 32'd0);
    chk("rst_pc",   alu_pc, 32'd0);
    chk("rst_rd",   {27'd0, alu_rd}, 32'd0);
    rst_in = 1'b0;
    tick();

    // Ready issue: ADD 5+7, tag 3
    set_issue(7'h01, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    sb_q.push_back(mk(7'h01, 32'd5, 32'd7, 5'd3));
    tick(); idle();
    chk("add_not_yet", {25'd0, alu_op}, 32'd0);
    tick();
    chk("add_disp", {25'd0, alu_op}, 32'h01);
    tick();
    chk("add_after", {25'd0, alu_op}, 32'd0);

    // Wakeup: SUB waits on tag 9, broadcast two cycles after issue
    set_issue(7'h02, 32'd0, 32'd1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd4);
    sb_q.push_back(mk(7'h02, 32'd10, 32'd1, 5'd4));
    tick(); idle();
    tick();
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'd10;
    tick(); idle();
`ifdef RS_WAKEUP_BYPASS_EN
    chk("wake_bcast_cyc", {25'd0, alu_op}, 32'h02);
    tick();
    chk("wake_next_cyc", {25'd0, alu_op}, 32'd0);
`else
    chk("wake_bcast_cyc", {25'd0, alu_op}, 32'd0);
    tick();
    chk("wake_next_cyc", {25'd0, alu_op}, 32'h02);
`endif
    tick();

    // Fill and back-pressure: 8 entries waiting on tag 2
    for (int i = 0; i < 8; i++) begin
      set_issue(7'h03, 32'd0, i, 1'b1, 5'd2, 1'b0, 5'd0, 5'(10 + i));
      tick();
    end
    chk("fill_full", {31'd0, full_out}, 32'd1);
    set_issue(7'h03, 32'd0, 32'd99, 1'b1, 5'd2, 1'b0, 5'd0, 5'd20);
    tick(); idle();
    chk("ninth_full", {31'd0, full_out}, 32'd1);
    chk("ninth_op", {25'd0, alu_op}, 32'd0);
    for (int i = 0; i < 8; i++) sb_q.push_back(mk(7'h03, 32'h22, i, 5'(10 + i)));
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'h22;
    tick(); idle();
`ifndef RS_WAKEUP_BYPASS_EN
    chk("fill_full_hold", {31'd0, full_out}, 32'd1);
    tick();
`endif
    chk("drain0_op", {25'd0, alu_op}, 32'h03);
    chk("drain0_full", {31'd0, full_out}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("drain_op", {25'd0, alu_op}, 32'h03);
    end
    tick();
    chk("drain_done", {25'd0, alu_op}, 32'd0);
    chk("drain_sb_empty", sb_q.size(), 32'd0);

    // Issue-cycle capture of qk from the CDB
    set_issue(7'h04, 32'h55, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd6);
    cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_value = 32'hDEAD;
    sb_q.push_back(mk(7'h04, 32'h55, 32'hDEAD, 5'd6));
    tick(); idle();
    tick();
    chk("cap_disp", {25'd0, alu_op}, 32'h04);
    tick();

    // Opcode 0 is dropped
    set_issue(7'h00, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    tick(); idle();
    tick();
    chk("op0_drop", {25'd0, alu_op}, 32'd0);

    // Flush and stall
    for (int i = 0; i < 3; i++) begin
      set_issue(7'h05, 32'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'(21 + i));
      tick();
    end
    set_issue(7'h06, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd24);
    sb_q.push_back(mk(7'h06, 32'd1, 32'd2, 5'd24));
    tick(); idle();
    tick();
    chk("pre_stall_op", {25'd0, alu_op}, 32'h06);
    rdy_in = 1'b0;
    set_issue(7'h06, 32'd3, 32'd3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd25);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_op", {25'd0, alu_op}, 32'h06);
      chk("stall_rd", {27'd0, alu_rd}, 32'd24);
      chk("stall_vi", alu_vi, 32'd1);
    end
    rdy_in = 1'b1; clear_in = 1'b1; cdb_valid = 1'b0;
    tick();
    chk("clear_op", {25'd0, alu_op}, 32'd0);
    chk("clear_full", {31'd0, full_out}, 32'd0);
    clear_in = 1'b0; idle();
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h77;
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flushed_idle", {25'd0, alu_op}, 32'd0);
    end
    chk("final_sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
